hazard_unit: RTL and testbench

//   Producer of the hazard_detected signal consumed by the ID-stage controller. Shadows the

---
 rtl/hazard_unit_if.sv | 37 +++
 rtl/hazard_unit.sv | 86 ++++++++
 tb/tb_hazard_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : hazard_unit_if                                                  |
// | Brief  : ID-stage request and stall-status bundle for hazard_unit        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface hazard_unit_if #(
    parameter int REG_ADDR_LEN = 5,
    parameter int STALL_CNT_W  = 16
);
    logic                    id_valid;
    logic [REG_ADDR_LEN-1:0] id_src1;
    logic [REG_ADDR_LEN-1:0] id_src2;
    logic                    id_two_src;
    logic [REG_ADDR_LEN-1:0] id_dest;
    logic                    id_wb_en;
    logic                    id_mem_r_en;
    logic                    id_is_mult;
    logic                    fwd_en;
    logic                    hazard_detected;
    logic                    pc_freeze;
    logic                    mult_busy;
    logic [STALL_CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_dest,
               id_wb_en, id_mem_r_en, id_is_mult, fwd_en,
        input  hazard_detected, pc_freeze, mult_busy, stall_count
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_dest,
               id_wb_en, id_mem_r_en, id_is_mult, fwd_en,
        output hazard_detected, pc_freeze, mult_busy, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : hazard_unit                                                     |
// | Brief  : RAW / MULT-structural stall detection with EXE/MEM shadow slots |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module hazard_unit #(
    parameter int REG_ADDR_LEN = 5,
    parameter int MULT_LAT     = 4,
    parameter int STALL_CNT_W  = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    hazard_unit_if.slave bus
);
    localparam int c_CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_LAT - 1);

    logic                    r_exe_v, r_exe_wb, r_exe_ld;
    logic [REG_ADDR_LEN-1:0] r_exe_dest;
    logic                    r_mem_v, r_mem_wb, r_mem_ld;
    logic [REG_ADDR_LEN-1:0] r_mem_dest;
    logic [c_CNT_W-1:0]      r_mult_cnt;
    logic [STALL_CNT_W-1:0]  r_stall_count;

    logic w_match_exe, w_match_mem, w_raw, w_mult_busy, w_hazard, w_issue;

    always_comb begin
        w_match_exe = r_exe_v && r_exe_wb && (r_exe_dest != '0) &&
                      ((r_exe_dest == bus.id_src1) ||
                       (bus.id_two_src && (r_exe_dest == bus.id_src2)));
        w_match_mem = r_mem_v && r_mem_wb && (r_mem_dest != '0) &&
                      ((r_mem_dest == bus.id_src1) ||
                       (bus.id_two_src && (r_mem_dest == bus.id_src2)));
        // With forwarding only a load still in EXE cannot supply its result in time
        w_raw       = bus.fwd_en ? (w_match_exe && r_exe_ld) : (w_match_exe || w_match_mem);
        w_mult_busy = (r_mult_cnt != '0);
        w_hazard    = bus.id_valid && (w_raw || w_mult_busy);
        w_issue     = bus.id_valid && !w_hazard;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe_v       <= 1'b0;
            r_exe_wb      <= 1'b0;
            r_exe_ld      <= 1'b0;
            r_exe_dest    <= '0;
            r_mem_v       <= 1'b0;
            r_mem_wb      <= 1'b0;
            r_mem_ld      <= 1'b0;
            r_mem_dest    <= '0;
            r_mult_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            r_mem_v    <= r_exe_v;
            r_mem_wb   <= r_exe_wb;
            r_mem_ld   <= r_exe_ld;
            r_mem_dest <= r_exe_dest;
            if (w_issue) begin
                r_exe_v    <= 1'b1;
                r_exe_wb   <= bus.id_wb_en;
                r_exe_ld   <= bus.id_mem_r_en;
                r_exe_dest <= bus.id_dest;
            end else begin
                r_exe_v    <= 1'b0;
                r_exe_wb   <= 1'b0;
                r_exe_ld   <= 1'b0;
                r_exe_dest <= '0;
            end
            if (w_issue && bus.id_is_mult) begin
                r_mult_cnt <= c_MULT_LOAD;
            end else if (w_mult_busy) begin
                r_mult_cnt <= r_mult_cnt - 1'b1;
            end
            if (w_hazard && !(&r_stall_count)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign bus.hazard_detected = w_hazard;
    assign bus.pc_freeze       = w_hazard;
    assign bus.mult_busy       = w_mult_busy;
    assign bus.stall_count     = r_stall_count;
endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_hazard_unit                                                  |
// | Brief  : table, directed and random checks of hazard_unit vs a model     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_unit_if #(.REG_ADDR_LEN(5), .STALL_CNT_W(16)) bus1 ();
    hazard_unit_if #(.REG_ADDR_LEN(5), .STALL_CNT_W(3))  bus2 ();

    assign bus2.id_valid    = bus1.id_valid;
    assign bus2.id_src1     = bus1.id_src1;
    assign bus2.id_src2     = bus1.id_src2;
    assign bus2.id_two_src  = bus1.id_two_src;
    assign bus2.id_dest     = bus1.id_dest;
    assign bus2.id_wb_en    = bus1.id_wb_en;
    assign bus2.id_mem_r_en = bus1.id_mem_r_en;
    assign bus2.id_is_mult  = bus1.id_is_mult;
    assign bus2.fwd_en      = bus1.fwd_en;

    hazard_unit #(.REG_ADDR_LEN(5), .MULT_LAT(4), .STALL_CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    hazard_unit #(.REG_ADDR_LEN(5), .MULT_LAT(1), .STALL_CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct packed {
        logic rst, v;
        logic [4:0] s1, s2;
        logic two;
        logic [4:0] d;
        logic wb, ld, mult, fwd;
    } in_t;

    typedef struct packed {
        in_t i;
        logic haz, busy;
        logic [15:0] cnt;
    } vec_t;

    typedef struct packed {
        logic v;
        logic [4:0] dest;
        logic wb, ld;
    } slot_t;

    int errors = 0;
    int checks = 0;

    // Model: instructions issued one and two cycles ago, cycles since last MULT issue
    slot_t ago1 [2];
    slot_t ago2 [2];
    int since_mult [2];
    int stalls [2];
    int lat [2];
    int cmax [2];

    function automatic vec_t mk(logic r, logic v, logic [4:0] s1, logic [4:0] s2, logic two,
                                logic [4:0] d, logic wb, logic ld, logic mult, logic fwd,
                                logic haz, logic busy, logic [15:0] cnt);
        vec_t e;
        e.i.rst = r;  e.i.v = v;  e.i.s1 = s1;  e.i.s2 = s2;  e.i.two = two;
        e.i.d = d;    e.i.wb = wb; e.i.ld = ld; e.i.mult = mult; e.i.fwd = fwd;
        e.haz = haz;  e.busy = busy; e.cnt = cnt;
        return e;
    endfunction

    function automatic logic m_match(slot_t s, in_t x);
        return s.v && s.wb && (s.dest != 5'd0) &&
               ((s.dest == x.s1) || (x.two && (s.dest == x.s2)));
    endfunction

    function automatic logic m_busy(int k);
        return since_mult[k] < lat[k];
    endfunction

    function automatic logic m_hazard(int k, in_t x);
        logic raw;
        if (x.fwd) raw = m_match(ago1[k], x) && ago1[k].ld;
        else       raw = m_match(ago1[k], x) || m_match(ago2[k], x);
        return x.v && (raw || m_busy(k));
    endfunction

    task automatic model_reset(int k);
        ago1[k] = '0;
        ago2[k] = '0;
        since_mult[k] = 1000;
        stalls[k] = 0;
    endtask

    task automatic model_update(int k, in_t x);
        logic h;
        if (x.rst) begin
            model_reset(k);
        end else begin
            h = m_hazard(k, x);
            if (h && stalls[k] < cmax[k]) stalls[k] = stalls[k] + 1;
            ago2[k] = ago1[k];
            ago1[k] = (x.v && !h) ? {1'b1, x.d, x.wb, x.ld} : '0;
            if (x.v && x.mult && !h) since_mult[k] = 1;
            else if (since_mult[k] < 1000) since_mult[k] = since_mult[k] + 1;
        end
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(in_t x);
        rst              = x.rst;
        bus1.id_valid    = x.v;
        bus1.id_src1     = x.s1;
        bus1.id_src2     = x.s2;
        bus1.id_two_src  = x.two;
        bus1.id_dest     = x.d;
        bus1.id_wb_en    = x.wb;
        bus1.id_mem_r_en = x.ld;
        bus1.id_is_mult  = x.mult;
        bus1.fwd_en      = x.fwd;
    endtask

    // Drive one cycle, compare at the falling edge, then advance past the rising edge
    task automatic run_cycle(in_t x, logic has_exp, vec_t e, string tag);
        drive(x);
        @(negedge clk);
        if (has_exp) begin
            check({tag, ".hazard"}, 16'(bus1.hazard_detected), 16'(e.haz));
            check({tag, ".freeze"}, 16'(bus1.pc_freeze), 16'(e.haz));
            check({tag, ".busy"},   16'(bus1.mult_busy), 16'(e.busy));
            check({tag, ".count"},  bus1.stall_count, e.cnt);
        end else begin
            check({tag, ".hazard"}, 16'(bus1.hazard_detected), 16'(m_hazard(0, x)));
            check({tag, ".freeze"}, 16'(bus1.pc_freeze), 16'(m_hazard(0, x)));
            check({tag, ".busy"},   16'(bus1.mult_busy), 16'(m_busy(0)));
            check({tag, ".count"},  bus1.stall_count, 16'(stalls[0]));
        end
        check({tag, ".l1_hazard"}, 16'(bus2.hazard_detected), 16'(m_hazard(1, x)));
        check({tag, ".l1_busy"},   16'(bus2.mult_busy), 16'(m_busy(1)));
        check({tag, ".l1_count"},  16'(bus2.stall_count), 16'(stalls[1]));
        model_update(0, x);
        model_update(1, x);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [26];
    vec_t none;
    in_t  x;

    initial begin
        lat[0] = 4;  lat[1] = 1;
        cmax[0] = 65535;  cmax[1] = 7;
        none = '0;

        tbl[0]  = mk(0,1, 1, 2,1, 3,1,0,0,0, 0,0,0);
        tbl[1]  = mk(0,1, 3, 4,1, 7,1,0,0,0, 1,0,0);
        tbl[2]  = mk(0,1, 3, 4,1, 7,1,0,0,0, 1,0,1);
        tbl[3]  = mk(0,1, 3, 4,1, 7,1,0,0,0, 0,0,2);
        tbl[4]  = mk(0,1, 1, 0,0, 5,1,1,0,1, 0,0,2);
        tbl[5]  = mk(0,1, 5, 1,1, 6,1,0,0,1, 1,0,2);
        tbl[6]  = mk(0,1, 5, 1,1, 6,1,0,0,1, 0,0,3);
        tbl[7]  = mk(0,1, 6, 6,1, 8,1,0,0,1, 0,0,3);
        tbl[8]  = mk(0,1, 1, 2,1, 0,1,0,0,0, 0,0,3);
        tbl[9]  = mk(0,1, 0, 0,1, 9,1,0,0,0, 0,0,3);
        tbl[10] = mk(0,1, 0, 0,1, 0,0,0,0,1, 0,0,3);
        tbl[11] = mk(0,1, 1, 9,0,10,1,0,0,0, 0,0,3);
        tbl[12] = mk(0,1, 1,10,0,11,1,0,0,0, 0,0,3);
        tbl[13] = mk(0,1, 1,11,1,12,1,0,0,0, 1,0,3);
        tbl[14] = mk(0,1, 1,11,1,12,1,0,0,0, 1,0,4);
        tbl[15] = mk(0,1, 1,11,1,12,1,0,0,0, 0,0,5);
        tbl[16] = mk(0,1, 1, 2,1,13,1,0,1,1, 0,0,5);
        tbl[17] = mk(0,1, 1, 2,1,14,1,0,0,1, 1,1,5);
        tbl[18] = mk(0,1, 1, 2,1,14,1,0,0,1, 1,1,6);
        tbl[19] = mk(0,1, 1, 2,1,14,1,0,0,1, 1,1,7);
        tbl[20] = mk(0,1, 1, 2,1,14,1,0,0,1, 0,0,8);
        tbl[21] = mk(0,1, 1, 2,1,15,1,0,1,1, 0,0,8);
        tbl[22] = mk(0,0, 1, 2,1,15,1,0,1,1, 0,1,8);
        tbl[23] = mk(0,1, 1, 2,1,16,1,0,0,1, 1,1,8);
        tbl[24] = mk(1,1, 1, 2,1,16,1,0,0,1, 1,1,9);
        tbl[25] = mk(0,1, 1, 2,1,16,1,0,0,1, 0,0,0);

        x = '0;
        x.rst = 1'b1;
        drive(x);
        repeat (2) @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);

        for (int i = 0; i < 26; i++) begin
            run_cycle(tbl[i].i, 1'b1, tbl[i], $sformatf("tbl%0d", i));
        end

        // Long dependent chain without forwarding drives the 3-bit counter into saturation
        x = '0;
        x.rst = 1'b1;
        run_cycle(x, 1'b0, none, "sat_rst");
        x = '0;
        x.v = 1'b1; x.s1 = 5'd1; x.s2 = 5'd2; x.two = 1'b1; x.d = 5'd3; x.wb = 1'b1;
        run_cycle(x, 1'b0, none, "sat_prod");
        x.s1 = 5'd3;
        for (int i = 0; i < 24; i++) run_cycle(x, 1'b0, none, "sat_chain");
        check("sat_l1_count", 16'(bus2.stall_count), 16'h0007);
        check("sat_count_16", bus1.stall_count, 16'd16);

        for (int i = 0; i < 600; i++) begin
            x.rst  = ($urandom_range(0, 59) == 0);
            x.v    = ($urandom_range(0, 7) != 0);
            x.s1   = 5'($urandom_range(0, 3));
            x.s2   = 5'($urandom_range(0, 3));
            x.two  = 1'($urandom_range(0, 1));
            x.d    = 5'($urandom_range(0, 3));
            x.wb   = ($urandom_range(0, 4) != 0);
            x.ld   = ($urandom_range(0, 2) == 0);
            x.mult = ($urandom_range(0, 9) == 0);
            x.fwd  = 1'($urandom_range(0, 1));
            run_cycle(x, 1'b0, none, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
